// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and the shared coordinate type.
package vga_timing_pkg;
  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  function automatic coord_t to_coord(input int v);
    return coord_t'(v);
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered visible/sync decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int VISIBLE    = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic   vga_clk,
  input  logic   reset_n,
  input  logic   en,
  output coord_t count,
  output logic   visible,
  output logic   sync_n,
  output logic   wrap
);
  localparam coord_t LAST = to_coord(TOTAL - 1);
  localparam coord_t VIS  = to_coord(VISIBLE);
  localparam coord_t SS   = to_coord(SYNC_START);
  localparam coord_t SE   = to_coord(SYNC_END);

  coord_t nxt;

  assign wrap = en && (count == LAST);

  always_comb begin
    nxt = count;
    if (en) nxt = (count == LAST) ? '0 : count + 1'b1;
  end

  // Decode from the next position so flags land on the same edge as count.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= LAST;
      visible <= 1'b0;
      sync_n  <= 1'b1;
    end else if (en) begin
      count   <= nxt;
      visible <= (nxt < VIS);
      sync_n  <= !((nxt >= SS) && (nxt < SE));
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: H/V axis counters plus line/frame pulses and frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int FRAME_W   = 16
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic               pix_ce,
  output coord_t             DrawX,
  output coord_t             DrawY,
  output logic               blank,
  output logic               hs,
  output logic               vs,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  logic h_vis, v_vis, h_wrap, v_wrap;

  vga_axis_counter #(
    .TOTAL(H_TOTAL), .VISIBLE(H_VISIBLE),
    .SYNC_START(H_VISIBLE + H_FP), .SYNC_END(H_VISIBLE + H_FP + H_SYNC)
  ) u_h (
    .vga_clk(vga_clk), .reset_n(reset_n), .en(pix_ce),
    .count(DrawX), .visible(h_vis), .sync_n(hs), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .TOTAL(V_TOTAL), .VISIBLE(V_VISIBLE),
    .SYNC_START(V_VISIBLE + V_FP), .SYNC_END(V_VISIBLE + V_FP + V_SYNC)
  ) u_v (
    .vga_clk(vga_clk), .reset_n(reset_n), .en(h_wrap & pix_ce),
    .count(DrawY), .visible(v_vis), .sync_n(vs), .wrap(v_wrap)
  );

  // Both inputs are flops updated on the same edge, so blank stays aligned.
  assign blank = h_vis & v_vis;

  // Wraps already include pix_ce, so pulses drop on any disabled edge.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '1;
    end else begin
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      if (v_wrap) frame_count <= frame_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size raster for line/reset checks, shrunk raster for frame/wrap checks.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n, rst_s, pix_ce;
  coord_t x, y, xs, ys;
  logic   blank, hs, vs, ls, fs;
  logic   blank_s, hs_s, vs_s, ls_s, fs_s;
  logic [15:0] fc;
  logic [3:0]  fc_s;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut (
    .vga_clk(clk), .reset_n(rst_n), .pix_ce(pix_ce),
    .DrawX(x), .DrawY(y), .blank(blank), .hs(hs), .vs(vs),
    .line_start(ls), .frame_start(fs), .frame_count(fc)
  );

  // 8x5 raster: visible 4x2, hsync x=5..6, vsync y=3, 40 edges per frame.
  vga_timing_gen #(
    .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .FRAME_W(4)
  ) u_small (
    .vga_clk(clk), .reset_n(rst_s), .pix_ce(pix_ce),
    .DrawX(xs), .DrawY(ys), .blank(blank_s), .hs(hs_s), .vs(vs_s),
    .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_x"}, 32'(x), 32'd799);
    chk({tag, "_y"}, 32'(y), 32'd524);
    chk({tag, "_flags"}, {27'd0, blank, hs, vs, ls, fs}, {27'd0, 5'b01100});
    chk({tag, "_fc"}, 32'(fc), 32'hFFFF);
  endtask

  initial begin
    int hs_low, hs_first, hs_last, ls_seen, viol, fs_cnt;
    coord_t px;
    rst_n = 1'b0; rst_s = 1'b0; pix_ce = 1'b0;
    step(3);
    chk_reset("reset");

    rst_n = 1'b1; pix_ce = 1'b1;
    step(1);
    chk("first_x", 32'(x), 32'd0);
    chk("first_y", 32'(y), 32'd0);
    chk("first_flags", {27'd0, blank, hs, vs, ls, fs}, {27'd0, 5'b11111});
    chk("first_fc", 32'(fc), 32'd0);

    step(639);
    chk("x639", {22'd0, x}, 32'd639);
    chk("x639_blank", 32'(blank), 32'd1);
    step(1);
    chk("x640_blank", 32'(blank), 32'd0);
    chk("x640_ls", 32'(ls), 32'd0);

    hs_low = 0; hs_first = -1; hs_last = -1;
    for (int i = 0; i < 159; i++) begin
      step(1);
      if (!hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(x);
        hs_last = int'(x);
      end
    end
    chk("hs_low_cnt", 32'(hs_low), 32'd96);
    chk("hs_first", 32'(hs_first), 32'd656);
    chk("hs_last", 32'(hs_last), 32'd751);
    chk("x799", 32'(x), 32'd799);

    step(1);
    chk("line1_pos", {12'd0, x, y}, {12'd0, 10'd0, 10'd1});
    chk("line1_pulses", {30'd0, ls, fs}, 32'b10);
    step(1);
    chk("ls_one_cycle", 32'(ls), 32'd0);

    // Toggle pix_ce across the line-1 to line-2 wrap.
    step(795);
    chk("pre_toggle_x", 32'(x), 32'd796);
    ls_seen = 0; viol = 0;
    for (int i = 0; i < 10; i++) begin
      pix_ce = (i % 2 == 0);
      px = x;
      step(1);
      if (!pix_ce && (ls || fs || x != px)) viol++;
      if (ls) ls_seen++;
    end
    chk("toggle_pos", {12'd0, x, y}, {12'd0, 10'd1, 10'd2});
    chk("toggle_viol", 32'(viol), 32'd0);
    chk("toggle_ls_cnt", 32'(ls_seen), 32'd1);

    pix_ce = 1'b1;
    step(299);
    chk("pre_rst_pos", {12'd0, x, y}, {12'd0, 10'd300, 10'd2});
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    chk("restart_pos", {12'd0, x, y}, 32'd0);
    chk("restart_fs", 32'(fs), 32'd1);
    chk("restart_fc", 32'(fc), 32'd0);

    // Shrunk raster: every position, pulse and frame count over >16 frames.
    rst_s = 1'b1;
    fs_cnt = 0;
    for (int e = 0; e < 700; e++) begin
      int ex, ey;
      logic eb, eh, ev, el, ef;
      logic [3:0] efc;
      step(1);
      ex = e % 8;
      ey = (e / 8) % 5;
      eb = (ex < 4) && (ey < 2);
      eh = !(ex == 5 || ex == 6);
      ev = (ey != 3);
      el = (ex == 0);
      ef = (ex == 0) && (ey == 0);
      efc = 4'((e / 40) % 16);
      if (fs_s) fs_cnt++;
      chk("small_state", {3'd0, xs, ys, blank_s, hs_s, vs_s, ls_s, fs_s, fc_s},
          {3'd0, 10'(ex), 10'(ey), eb, eh, ev, el, ef, efc});
      if (e == 640) chk("small_fc_wrap", 32'(fc_s), 32'd0);
    end
    chk("small_fs_cnt", 32'(fs_cnt), 32'd18);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480@60 raster timing that every sprite/colour-mapping block in the display path consumes. Produces DrawX/DrawY, active-high `blank` (1 = visible pixel), active-low hs/vs, and one-cycle line/frame markers. Also produces a free-running frame counter for sprite animation phase selection. All outputs are registered and mutually aligned to the same raster position.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
- FRAME_W, 16, frame counter width
- vga_clk  in  1  pixel-domain clock; one clock, all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- pix_ce  in  1  pixel clock-enable; raster advances only on edges where pix_ce=1
- DrawX  out  10  current column, 0..H_TOTAL-1 (H_TOTAL=800)
- DrawY  out  10  current line, 0..V_TOTAL-1 (V_TOTAL=525)
- blank  out  1  1 when DrawX<H_VISIBLE and DrawY<V_VISIBLE
- hs  out  1  low while H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (656..751)
- vs  out  1  low while V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (490..491)
- line_start  out  1  one-cycle pulse on the advance into DrawX=0
- frame_start  out  1  one-cycle pulse on the advance into (0,0)
- frame_count  out  FRAME_W  number of frames begun since reset, minus one; wraps

## Operation
- Horizontal counter: increments by 1 per advance; at H_TOTAL-1 wraps to 0 and advances the vertical counter.
- Vertical counter: increments only on horizontal wrap; at V_TOTAL-1 with horizontal wrap, wraps to 0.
- blank/hs/vs decoded from the next counter values and registered, so they change on the same edge as DrawX/DrawY.
- frame_count increments (modulo 2^FRAME_W) on every advance into (0,0).
- Edge with pix_ce=0: DrawX, DrawY, blank, hs, vs, frame_count hold; line_start and frame_start forced to 0.
- A pulse never lasts more than one vga_clk cycle, even if pix_ce stays high across the next position.
- Parameters are elaboration-time only; H_TOTAL/V_TOTAL are parameter sums and must fit in 10 bits.

## Timing
- Reset values (async, immediate): DrawX=H_TOTAL-1 (799), DrawY=V_TOTAL-1 (524), blank=0, hs=1, vs=1, line_start=0, frame_start=0, frame_count=all ones.
- First pix_ce=1 edge after reset_n rises: DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, frame_count=0.
- Latency: 0 cycles between counter position and its decoded outputs (same register stage).
- Downstream consumers with a 1-cycle ROM stage see colour one cycle after DrawX; compensation is the consumer's responsibility.
- Line period 800 enabled edges; frame period 420000 enabled edges.
- Reset asserted mid-frame: all outputs return to reset values asynchronously; no partial pulse survives.

## Structure
- Package vga_timing_pkg: default timing constants (visible/porch/sync for H and V), derived H_TOTAL/V_TOTAL, and a 10-bit coord_t typedef.
- One sub-module is natural: vga_axis_counter (parameters TOTAL, VISIBLE, SYNC_START, SYNC_END; inputs count enable; outputs count, visible, sync_n, wrap), instantiated once for H and once for V (V enable = H wrap & pix_ce).
- Top level combines axis outputs into blank, pulses and frame_count.

## Test plan
- Reset then pix_ce=1 constant -> first edge DrawX=0, DrawY=0, blank=1, frame_start=1, frame_count=0; DrawX=639 blank=1, DrawX=640 blank=0.
- Run one full line -> hs low exactly for DrawX 656..751 (96 cycles); line_start high only at DrawX=0 of next line.
- Run two full frames -> vs low for DrawY 490..491 only (1600 cycles); frame_start once per 420000 edges; frame_count 0 then 1.
- pix_ce toggling 1,0,1,0 -> raster advances every other cycle; line_start/frame_start never high on a pix_ce=0 edge, never 2 cycles wide.
- Assert reset_n=0 asynchronously at DrawX=300, DrawY=200 -> outputs immediately 799/524/blank=0/hs=1/vs=1; restart gives frame_start at (0,0).
- Force frame_count to 16'hFFFF via 65536 frames (or shortened-parameter build V_VISIBLE=2, H_VISIBLE=4) -> wraps to 0 with no glitch on other outputs.
